// File: rtl/add_pkg.sv
// Shared constants and state encoding for the add_fsm initiator and its reference model.
package add_pkg;

  localparam int OP_W            = 6;
  localparam int ADD_CONST       = 3;
  localparam int LATENCY_DEFAULT = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } drv_state_t;

endpackage

// File: rtl/add_ref_model.sv
// Combinational expected-value calculator mirroring add_fsm: x=a+b, y=x+3, result=x+y.
module add_ref_model
  import add_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] expected
);

  logic [WIDTH-1:0] sum_x;
  logic [WIDTH-1:0] sum_y;

  // Every stage truncates to WIDTH bits, matching the wrap-around of add_fsm.
  assign sum_x    = a + b;
  assign sum_y    = sum_x + WIDTH'(ADD_CONST);
  assign expected = sum_x + sum_y;

endmodule

// File: rtl/add_fsm_driver.sv
// Initiator for add_fsm: issues one operand pair per go pulse, waits the fixed latency,
// captures and checks the result, and keeps saturating transaction/error counters.
module add_fsm_driver
  import add_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int LATENCY = LATENCY_DEFAULT,
  parameter int CNT_W   = 8
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OP_W-1:0]  req_a,
  input  logic [OP_W-1:0]  req_b,
  output logic             go,
  output logic [OP_W-1:0]  a,
  output logic [OP_W-1:0]  b,
  input  logic [OP_W-1:0]  result_in,
  output logic             rsp_valid,
  output logic [OP_W-1:0]  rsp_result,
  output logic             rsp_error,
  output logic [CNT_W-1:0] txn_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int WC_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  drv_state_t       state;
  drv_state_t       state_next;
  logic [WC_W-1:0]  wait_cnt;
  logic [OP_W-1:0]  expected;
  logic             accept;
  logic             mismatch;

  add_ref_model #(.WIDTH(OP_W)) u_ref (
    .a        (a),
    .b        (b),
    .expected (expected)
  );

  assign accept   = req_valid && req_ready;
  assign mismatch = (result_in != expected);

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    go         = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = ISSUE;
      end
      ISSUE: begin
        go         = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (wait_cnt == '0) state_next = CAPTURE;
      end
      CAPTURE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operands stay on a/b from the accept edge until the next accept, so add_fsm
  // and the reference model both see them for the whole transaction.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      a          <= '0;
      b          <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_error  <= 1'b0;
      txn_count  <= '0;
      err_count  <= '0;
    end else begin
      state     <= state_next;
      rsp_valid <= (state == CAPTURE);
      if (accept) begin
        a <= req_a;
        b <= req_b;
      end
      if (state == ISSUE) begin
        wait_cnt <= WC_W'(LATENCY - 1);
      end else if (state == WAIT && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - 1'b1;
      end
      if (state == CAPTURE) begin
        rsp_result <= result_in;
        rsp_error  <= mismatch;
        if (txn_count != '1) txn_count <= txn_count + 1'b1;
        if (mismatch && err_count != '1) err_count <= err_count + 1'b1;
      end
    end
  end

endmodule
